// File: rtl/cpu_commit_memctrl.sv
// cpu_commit_memctrl: commit-stage load/store sequencer with data-memory handshake and bus timeout
module cpu_commit_memctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      op_valid,
  input  logic                      op_load,
  input  logic                      op_store,
  input  logic [1:0]                op_size,
  input  logic                      op_unsigned,
  input  logic [ADDR_WIDTH-1:0]     op_addr,
  input  logic [DATA_WIDTH-1:0]     op_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] op_reg_dest,
  output logic                      stall,
  output logic                      wb_valid,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_dest,
  output logic                      err_misaligned,
  output logic                      err_bus,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [3:0]                mem_be,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t                    st;
  logic [CW-1:0]             cnt;
  logic [1:0]                lane, size_q;
  logic                      uns_q, load_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      mem_op, mis, accept, expired;
  logic [3:0]                be;
  logic [DATA_WIDTH-1:0]     wd, ext;
  logic [7:0]                rb;
  logic [15:0]               rh;
  always_comb begin
    mem_op  = op_valid && (op_load || op_store);
    mis     = op_size == 2'b00 ? 1'b0 : op_size == 2'b01 ? op_addr[0] : |op_addr[1:0];
    accept  = st == IDLE && mem_op && !mis;
    stall   = st == REQ || st == WAIT || accept;
    expired = cnt == CW'(TIMEOUT - 1);
    be      = op_size == 2'b00 ? 4'b0001 << op_addr[1:0] : op_size == 2'b01 ? 4'b0011 << op_addr[1:0] : 4'b1111;
    wd      = op_size == 2'b00 ? {4{op_wdata[7:0]}} : op_size == 2'b01 ? {2{op_wdata[15:0]}} : op_wdata;
    rb      = mem_rdata[{lane, 3'b000} +: 8];
    rh      = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext     = size_q == 2'b00 ? {{24{~uns_q & rb[7]}}, rb} :
              size_q == 2'b01 ? {{16{~uns_q & rh[15]}}, rh} : mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= IDLE;
      cnt            <= '0;
      lane           <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      load_q         <= 1'b0;
      rd_q           <= '0;
      wb_valid       <= 1'b0;
      wb_data        <= '0;
      wb_reg_dest    <= '0;
      err_misaligned <= 1'b0;
      err_bus        <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_be         <= '0;
      mem_wdata      <= '0;
    end else begin
      wb_valid       <= 1'b0;
      err_misaligned <= 1'b0;
      err_bus        <= 1'b0;
      case (st)
        IDLE: begin
          if (mem_op && mis) err_misaligned <= 1'b1;
          if (accept) begin
            st        <= REQ;
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_we    <= !op_load;
            mem_addr  <= {op_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be    <= be;
            mem_wdata <= wd;
            lane      <= op_addr[1:0];
            size_q    <= op_size;
            uns_q     <= op_unsigned;
            load_q    <= op_load;
            rd_q      <= op_reg_dest;
          end
        end
        REQ, WAIT: begin
          cnt <= cnt + 1'b1;
          if (st == WAIT && mem_rvalid) begin
            st <= DONE;
            if (load_q) begin
              wb_valid    <= 1'b1;
              wb_data     <= ext;
              wb_reg_dest <= rd_q;
            end
          end else if (expired) begin
            st      <= DONE;
            err_bus <= 1'b1;
            mem_req <= 1'b0;
          end else if (st == REQ && mem_gnt) begin
            st      <= WAIT;
            mem_req <= 1'b0;
          end
        end
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_commit_memctrl.sv
// tb_cpu_commit_memctrl: directed stimulus with queued expectations checked by a separate output monitor
module tb_cpu_commit_memctrl;
  logic        clk = 0, rst_n = 0;
  logic        op_valid = 0, op_load = 0, op_store = 0, op_unsigned = 0;
  logic [1:0]  op_size = 0;
  logic [31:0] op_addr = 0, op_wdata = 0;
  logic [4:0]  op_reg_dest = 0;
  logic        stall, wb_valid, err_misaligned, err_bus, mem_req, mem_we;
  logic [31:0] wb_data, mem_addr, mem_wdata;
  logic [4:0]  wb_reg_dest;
  logic [3:0]  mem_be;
  logic        mem_gnt = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;

  always #5 clk = ~clk;

  cpu_commit_memctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
    .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata),
    .op_reg_dest(op_reg_dest), .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_reg_dest(wb_reg_dest), .err_misaligned(err_misaligned), .err_bus(err_bus),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct packed {logic [2:0] code; logic [31:0] data; logic [4:0] rd;} ev_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;} rq_t;
  ev_t evq[$];
  rq_t rqq[$];
  ev_t e;
  rq_t r;
  int total = 0, bad = 0, stall_cnt = 0;
  logic prev_req = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask

  task automatic push_ev(input logic [2:0] c, input logic [31:0] d, input logic [4:0] rd);
    evq.push_back(ev_t'({c, d, rd}));
  endtask

  task automatic push_rq(input logic we, input logic [31:0] a, input logic [3:0] b, input logic [31:0] w);
    rqq.push_back(rq_t'({we, a, b, w}));
  endtask

  // code: 001 writeback, 010 misaligned, 100 bus error
  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (wb_valid | err_misaligned | err_bus) begin
      if (evq.size() == 0) chk("unexpected_event", {err_bus, err_misaligned, wb_valid}, 0);
      else begin
        e = evq.pop_front();
        chk("event_kind", {err_bus, err_misaligned, wb_valid}, e.code);
        if (e.code == 3'b001) begin
          chk("wb_data", wb_data, e.data);
          chk("wb_reg_dest", wb_reg_dest, e.rd);
        end
      end
    end
    if (mem_req && !prev_req) begin
      if (rqq.size() == 0) chk("unexpected_req", mem_req, 0);
      else begin
        r = rqq.pop_front();
        chk("req_we", mem_we, r.we);
        chk("req_addr", mem_addr, r.addr);
        chk("req_be", mem_be, r.be);
        if (r.we) chk("req_wdata", mem_wdata, r.wd);
      end
    end
    prev_req <= mem_req;
  end

  task automatic chk_reset(input string n);
    chk({n, "_ctrl"}, {stall, err_bus, err_misaligned, wb_valid, mem_req, mem_we}, 0);
    chk({n, "_wb"}, {wb_reg_dest, wb_data}, 0);
    chk({n, "_mem"}, {mem_be, mem_addr}, 0);
    chk({n, "_wdata"}, mem_wdata, 0);
  endtask

  task automatic op(input logic ld, input logic st, input logic [1:0] sz, input logic un,
                    input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                    input int gw, input int rw, input bit never, input logic [31:0] rdata,
                    input int exp_stall, input bit access);
    bit done;
    done = 0;
    stall_cnt = 0;
    op_valid = 1; op_load = ld; op_store = st; op_size = sz; op_unsigned = un;
    op_addr = a; op_wdata = wd; op_reg_dest = rd;
    @(posedge clk); #1;
    op_valid = 0; op_load = 0; op_store = 0;
    if (access) begin
      repeat (gw) begin @(posedge clk); #1; end
      mem_gnt = 1;
      @(posedge clk); #1;
      mem_gnt = 0;
      for (int k = 0; k < 12 && !done; k++) begin
        if (!never && k == rw) begin mem_rvalid = 1; mem_rdata = rdata; end
        @(posedge clk); #1;
        mem_rvalid = 0;
        if (!stall) done = 1;
      end
      if (!done) chk("completion_bound", 0, 1);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stall_cycles", stall_cnt, exp_stall);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1;
    @(posedge clk); #1;
    push_rq(0, 32'h100, 4'hF, 0); push_ev(3'b001, 32'hDEADBEEF, 5);
    op(1, 0, 2'b10, 0, 32'h100, 0, 5, 0, 1, 0, 32'hDEADBEEF, 4, 1);
    push_rq(1, 32'h200, 4'b1000, 32'hA5A5A5A5);
    op(0, 1, 2'b00, 0, 32'h203, 32'hA5, 0, 1, 0, 0, 0, 4, 1);
    push_rq(0, 32'h100, 4'b1100, 0); push_ev(3'b001, 32'hFFFF8001, 7);
    op(1, 0, 2'b01, 0, 32'h102, 0, 7, 0, 0, 0, 32'h80011234, 3, 1);
    push_rq(0, 32'h100, 4'b1100, 0); push_ev(3'b001, 32'h00008001, 8);
    op(1, 0, 2'b01, 1, 32'h102, 0, 8, 0, 0, 0, 32'h80011234, 3, 1);
    push_rq(0, 32'h100, 4'b0010, 0); push_ev(3'b001, 32'hFFFFFF83, 9);
    op(1, 0, 2'b00, 0, 32'h101, 0, 9, 0, 0, 0, 32'h11228344, 3, 1);
    push_rq(1, 32'h300, 4'b1100, 32'hBEEFBEEF);
    op(0, 1, 2'b01, 0, 32'h302, 32'h1234BEEF, 0, 0, 1, 0, 0, 4, 1);
    push_rq(0, 32'h600, 4'hF, 0); push_ev(3'b001, 32'h0000007F, 3);
    op(1, 1, 2'b11, 0, 32'h600, 0, 3, 0, 0, 0, 32'h0000007F, 3, 1);
    push_ev(3'b010, 0, 0);
    op(1, 0, 2'b10, 0, 32'h101, 0, 1, 0, 0, 0, 0, 0, 0);
    push_ev(3'b010, 0, 0);
    op(0, 1, 2'b01, 0, 32'h103, 32'h55, 0, 0, 0, 0, 0, 0, 0);
    push_rq(0, 32'h400, 4'hF, 0); push_ev(3'b100, 0, 0);
    op(1, 0, 2'b10, 0, 32'h400, 0, 4, 0, 0, 1, 0, 5, 1);
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 0;
    chk("late_rvalid_stall", stall, 0);
    repeat (2) @(posedge clk);
    #1;
    push_rq(0, 32'h700, 4'hF, 0);
    op_valid = 1; op_load = 1; op_size = 2'b10; op_addr = 32'h700; op_reg_dest = 6;
    @(posedge clk); #1;
    op_valid = 0; op_load = 0;
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    rst_n = 0;
    #1;
    chk_reset("reset_mid_op");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    push_rq(0, 32'h500, 4'hF, 0); push_ev(3'b001, 32'h0BADF00D, 2);
    op(1, 0, 2'b10, 0, 32'h500, 0, 2, 0, 0, 0, 32'h0BADF00D, 3, 1);
    chk("events_left", evq.size(), 0);
    chk("requests_left", rqq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_commit_memctrl.md
# cpu_commit_memctrl

Load/store sequencer for the commit stage: accepts one memory operation at a time from commit, drives the data-memory request/grant/response handshake, stalls the pipeline until the access completes, and returns aligned, extended load data for register writeback. It sits between commit and data memory. A bounded timeout guards against a hung bus.

## Interface
- DATA_WIDTH, 32, data and register width (fixed at 32; 4 byte lanes)
- ADDR_WIDTH, 32, byte address width
- REG_ADDR_WIDTH, 5, destination register index width
- TIMEOUT, 255, max cycles spent in REQ+WAIT before bus error; must be at least 1
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  commit presents an instruction
- op_load / op_store  in  1 each  operation type; op_load wins if both set
- op_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- op_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- op_addr  in  ADDR_WIDTH  byte address
- op_wdata  in  DATA_WIDTH  store data, LSB-justified
- op_reg_dest  in  REG_ADDR_WIDTH  load destination
- stall  out  1  hold commit and earlier stages
- wb_valid  out  1  load result valid (1-cycle pulse)
- wb_data  out  DATA_WIDTH  extended load data
- wb_reg_dest  out  REG_ADDR_WIDTH  load destination
- err_misaligned  out  1  1-cycle pulse, misaligned access rejected
- err_bus  out  1  1-cycle pulse, timeout
- mem_req  out  1  request, held until mem_gnt
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_WIDTH  {op_addr[ADDR_WIDTH-1:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response: read data or write ack
- mem_rdata  in  DATA_WIDTH  read word

## Operation
- States: IDLE, REQ, WAIT, DONE; reset to IDLE.
- IDLE, op_valid & (op_load|op_store):
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0): err_misaligned=1 next cycle, no memory access, stay IDLE, stall=0.
  - Otherwise: capture addr/size/unsigned/wdata/reg_dest/type, stall=1 combinationally this cycle, go to REQ.
- IDLE, no memory op: stall=0.
- REQ: mem_req=1, stall=1, mem_* from captured fields. mem_gnt=1 -> WAIT.
- WAIT: stall=1. mem_rvalid=1 -> DONE; loads latch extended data into wb_data.
- DONE: stall=0 so commit advances. wb_valid=1 for loads only, 0 for stores. op_valid is ignored (still the finished instruction). Next state IDLE.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Store data: byte replicated to all 4 lanes; half replicated to both halves; word as-is.
- Load extract: byte lane addr[1:0]; half lane addr[1]. Extend per op_unsigned to 32 bits.
- Timeout counter: cleared on entering REQ, increments each REQ/WAIT cycle. Reaching TIMEOUT -> DONE with err_bus=1, wb_valid=0, mem_req dropped. A late mem_rvalid in IDLE is ignored.
- mem_rvalid arriving in REQ before or with mem_gnt is ignored; a response is only taken in WAIT.

## Timing
- Reset (reset=0, asynchronous): state IDLE, counter 0. All outputs 0, including stall, mem_req, wb_valid, wb_data, wb_reg_dest, err_*, mem_be, mem_addr, mem_wdata.
- Reset mid-operation: immediate return to IDLE, mem_req deasserts asynchronously, no writeback, no error pulse.
- Best-case latency, accept -> wb_valid: accept cycle (IDLE), REQ with gnt, WAIT with rvalid, DONE = 4 cycles. stall is high for exactly the first 3.
- wb_*, err_* are registered. mem_* are registered from captured fields. stall is combinational from state and, in IDLE only, from op_valid/op_load/op_store/alignment.
- mem_req stays high with stable mem_addr/mem_be/mem_wdata/mem_we until mem_gnt is sampled high.

## Test plan
- Word load at 0x100, gnt in REQ cycle 1, rvalid 2 cycles later with 0xDEADBEEF -> mem_be=4'hF, mem_addr=0x100, stall high 4 cycles, wb_valid pulse with wb_data=0xDEADBEEF and correct wb_reg_dest.
- Byte store 0xA5 at 0x203 -> mem_we=1, mem_addr=0x200, mem_be=4'b1000, mem_wdata=0xA5A5A5A5; DONE with wb_valid=0.
- Signed half load at 0x102, rdata 0x8001_1234 -> wb_data=0xFFFF8001. Same access with op_unsigned=1 -> wb_data=0x00008001.
- Word load at 0x101 -> err_misaligned pulse, mem_req never asserted, stall=0.
- TIMEOUT=4, gnt given, rvalid never arrives -> err_bus pulse after 4 REQ/WAIT cycles, wb_valid=0, stall released in DONE. A later rvalid is ignored.
- Reset asserted during WAIT -> all outputs 0 at once. After release, a new load completes normally.
